// File: rtl/axis_fifo_ctrl_sc.sv
// Single-clock AXIS read controller: unpacks util_fifo words into a 2-entry
// registered output buffer, with optional word-granular store-and-forward gating.
module axis_fifo_ctrl_sc #(
    parameter int unsigned BUS_WIDTH   = 1,
    parameter int unsigned USER_WIDTH  = 1,
    parameter int unsigned DEST_WIDTH  = 1,
    parameter int unsigned FIFO_POWER  = 8,
    parameter int unsigned PACKET_MODE = 0
) (
    input  logic                                                   aclk,
    input  logic                                                   arst,
    output logic                                                   m_axis_tvalid,
    input  logic                                                   m_axis_tready,
    output logic [BUS_WIDTH*8-1:0]                                 m_axis_tdata,
    output logic [BUS_WIDTH-1:0]                                   m_axis_tkeep,
    output logic                                                   m_axis_tlast,
    output logic [USER_WIDTH-1:0]                                  m_axis_tuser,
    output logic [DEST_WIDTH-1:0]                                  m_axis_tdest,
    input  logic                                                   wr_en,
    input  logic                                                   wr_tlast,
    input  logic                                                   wr_full,
    output logic                                                   rd_en,
    input  logic                                                   rd_valid,
    input  logic [BUS_WIDTH*8+BUS_WIDTH+USER_WIDTH+DEST_WIDTH:0]   rd_data,
    input  logic                                                   rd_empty,
    output logic [FIFO_POWER:0]                                    pkt_count,
    output logic                                                   pkt_flush
);
    localparam int unsigned DW = BUS_WIDTH * 8;
    localparam int unsigned WW = DW + BUS_WIDTH + USER_WIDTH + DEST_WIDTH + 1;
    localparam int unsigned CW = FIFO_POWER + 1;
    localparam int unsigned U_LO = DEST_WIDTH + 1;
    localparam int unsigned K_LO = U_LO + USER_WIDTH;
    localparam bit PM = (PACKET_MODE != 0);
    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = {1'b1, {FIFO_POWER{1'b0}}};

    typedef struct packed {
        logic          ftail;
        logic [WW-1:0] word;
    } ent_t;

    ent_t          head_q, tail_q, new_ent;
    logic [1:0]    occ_q, level;
    logic          inflight_q, inflight_tail_q;
    logic          full_q, pkt_flush_q, fl_mark_q, fl_mark_d;
    logic [CW-1:0] pend_q, pend_d, rel_q, rel_d, pkt_q, pkt_d, fl_left_q, fl_left_d;
    logic          pop, allow, wr_acc, commit, force_rel, rd_tail, inc, dec;

    assign m_axis_tvalid = (occ_q != 2'd0);
    assign pop           = m_axis_tvalid & m_axis_tready;

    assign m_axis_tdata = m_axis_tvalid ? head_q.word[WW-1:WW-DW]         : '0;
    assign m_axis_tkeep = m_axis_tvalid ? head_q.word[K_LO+BUS_WIDTH-1:K_LO] : '0;
    assign m_axis_tuser = m_axis_tvalid ? head_q.word[U_LO+USER_WIDTH-1:U_LO] : '0;
    assign m_axis_tdest = m_axis_tvalid ? head_q.word[DEST_WIDTH:1]       : '0;
    assign m_axis_tlast = m_axis_tvalid ? head_q.word[0]                  : 1'b0;

    assign level  = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    assign allow  = !PM || (rel_q != '0);
    assign rd_en  = !arst && !rd_empty && allow && (level < 2'd2);

    assign wr_acc    = wr_en && !wr_full;
    assign commit    = PM && wr_acc && wr_tlast;
    assign force_rel = PM && wr_full && !full_q && (pend_q != '0);

    assign inc = commit || force_rel;
    assign dec = PM && pop && (head_q.word[0] || head_q.ftail);

    assign new_ent   = '{ftail: inflight_tail_q, word: rd_data};
    assign pkt_count = pkt_q;
    assign pkt_flush = pkt_flush_q;

    always_comb begin
        pend_d    = pend_q;
        rel_d     = rel_q;
        fl_left_d = fl_left_q;
        fl_mark_d = fl_mark_q;
        rd_tail   = 1'b0;
        pkt_d     = pkt_q;
        if (commit) begin
            rel_d  = rel_q + pend_q + ONE;
            pend_d = '0;
        end else if (PM && wr_acc) begin
            pend_d = pend_q + ONE;
        end else if (force_rel) begin
            rel_d  = rel_q + pend_q;
            pend_d = '0;
        end
        if (PM && rd_en) rel_d = rel_d - ONE;
        // Flush tail is located by counting released words ahead of it in read order.
        if (rd_en && fl_mark_q) begin
            if (fl_left_q == ONE) begin
                rd_tail   = 1'b1;
                fl_mark_d = 1'b0;
            end else begin
                fl_left_d = fl_left_q - ONE;
            end
        end
        if (force_rel) begin
            fl_left_d = rel_q + pend_q - (rd_en ? ONE : '0);
            fl_mark_d = 1'b1;
        end
        if (inc && !dec && pkt_q != CNT_MAX) pkt_d = pkt_q + ONE;
        else if (dec && !inc && pkt_q != '0) pkt_d = pkt_q - ONE;
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            head_q          <= '0;
            tail_q          <= '0;
            occ_q           <= 2'd0;
            inflight_q      <= 1'b0;
            inflight_tail_q <= 1'b0;
            full_q          <= 1'b0;
            pkt_flush_q     <= 1'b0;
            fl_mark_q       <= 1'b0;
            fl_left_q       <= '0;
            pend_q          <= '0;
            rel_q           <= '0;
            pkt_q           <= '0;
        end else begin
            inflight_q      <= rd_en;
            inflight_tail_q <= rd_tail;
            full_q          <= wr_full;
            pkt_flush_q     <= force_rel;
            fl_mark_q       <= fl_mark_d;
            fl_left_q       <= fl_left_d;
            pend_q          <= pend_d;
            rel_q           <= rel_d;
            pkt_q           <= pkt_d;
            case ({rd_valid, pop})
                2'b10: begin
                    if (occ_q == 2'd0) head_q <= new_ent;
                    else               tail_q <= new_ent;
                    occ_q <= occ_q + 2'd1;
                end
                2'b01: begin
                    head_q <= tail_q;
                    occ_q  <= occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        head_q <= new_ent;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= new_ent;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_axis_fifo_ctrl_sc.sv
// Directed bench: lane 0 is stream-through, lane 1 is store-and-forward,
// each fed by a small behavioural util_fifo (depth 16, 1-cycle read latency).
module tb_axis_fifo_ctrl_sc;
    logic clk = 1'b0;
    logic arst;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic        wr_en    [2];
    logic [11:0] wr_word  [2];
    logic        tready   [2];
    logic        wr_full  [2];
    logic        rd_empty [2];
    logic        rd_en    [2];
    logic        rd_valid [2];
    logic [11:0] rd_data  [2];
    logic        tvalid   [2];
    logic        tlast    [2];
    logic        tkeep    [2];
    logic        tuser    [2];
    logic        tdest    [2];
    logic        pflush   [2];
    logic [7:0]  tdata    [2];
    logic [4:0]  pcnt     [2];

    axis_fifo_ctrl_sc #(
        .BUS_WIDTH(1), .USER_WIDTH(1), .DEST_WIDTH(1), .FIFO_POWER(4), .PACKET_MODE(0)
    ) dut0 (
        .aclk(clk), .arst(arst),
        .m_axis_tvalid(tvalid[0]), .m_axis_tready(tready[0]), .m_axis_tdata(tdata[0]),
        .m_axis_tkeep(tkeep[0]), .m_axis_tlast(tlast[0]), .m_axis_tuser(tuser[0]),
        .m_axis_tdest(tdest[0]), .wr_en(wr_en[0]), .wr_tlast(wr_word[0][0]),
        .wr_full(wr_full[0]), .rd_en(rd_en[0]), .rd_valid(rd_valid[0]),
        .rd_data(rd_data[0]), .rd_empty(rd_empty[0]), .pkt_count(pcnt[0]),
        .pkt_flush(pflush[0])
    );

    axis_fifo_ctrl_sc #(
        .BUS_WIDTH(1), .USER_WIDTH(1), .DEST_WIDTH(1), .FIFO_POWER(4), .PACKET_MODE(1)
    ) dut1 (
        .aclk(clk), .arst(arst),
        .m_axis_tvalid(tvalid[1]), .m_axis_tready(tready[1]), .m_axis_tdata(tdata[1]),
        .m_axis_tkeep(tkeep[1]), .m_axis_tlast(tlast[1]), .m_axis_tuser(tuser[1]),
        .m_axis_tdest(tdest[1]), .wr_en(wr_en[1]), .wr_tlast(wr_word[1][0]),
        .wr_full(wr_full[1]), .rd_en(rd_en[1]), .rd_valid(rd_valid[1]),
        .rd_data(rd_data[1]), .rd_empty(rd_empty[1]), .pkt_count(pcnt[1]),
        .pkt_flush(pflush[1])
    );

    for (genvar g = 0; g < 2; g++) begin : g_fifo
        logic [11:0] mem [16];
        logic [3:0]  wp, rp;
        logic [4:0]  cnt;
        assign wr_full[g]  = (cnt == 5'd16);
        assign rd_empty[g] = (cnt == 5'd0);
        always @(posedge clk) begin
            if (arst) begin
                cnt         <= 5'd0;
                wp          <= 4'd0;
                rp          <= 4'd0;
                rd_valid[g] <= 1'b0;
                rd_data[g]  <= '0;
            end else begin
                if (wr_en[g] && !wr_full[g]) begin
                    mem[wp] <= wr_word[g];
                    wp      <= wp + 4'd1;
                end
                if (rd_en[g] && !rd_empty[g]) begin
                    rd_data[g] <= mem[rp];
                    rp         <= rp + 4'd1;
                end
                rd_valid[g] <= rd_en[g] && !rd_empty[g];
                cnt <= cnt + 5'(wr_en[g] && !wr_full[g]) - 5'(rd_en[g] && !rd_empty[g]);
            end
        end
    end

    function automatic logic [11:0] w(input logic [7:0] d, input logic last);
        return {d, 1'b1, 1'b0, 1'b0, last};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int          bocc;
        int          binfl;
        int          nrx;
        logic        pop;
        logic        hold_v;
        logic [7:0]  hold_d;
        logic [7:0]  rx [16];
        logic        v;

        for (int i = 0; i < 2; i++) begin
            wr_en[i]   = 1'b0;
            wr_word[i] = '0;
            tready[i]  = 1'b1;
        end
        arst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_tvalid%0d", i), 32'(tvalid[i]), 32'd0);
            chk($sformatf("rst_rd_en%0d", i),  32'(rd_en[i]),  32'd0);
            chk($sformatf("rst_pcnt%0d", i),   32'(pcnt[i]),   32'd0);
            chk($sformatf("rst_tdata%0d", i),  32'(tdata[i]),  32'd0);
        end
        @(negedge clk);
        arst = 1'b0;

        // Mode 0 full-throughput stream
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            wr_en[0]   = (k < 8);
            wr_word[0] = w(8'(k + 1), 1'b0);
            #1;
            v = (k >= 3 && k <= 10);
            chk($sformatf("t1_rd_en k%0d", k),  32'(rd_en[0]),  32'(k >= 1 && k <= 8));
            chk($sformatf("t1_tvalid k%0d", k), 32'(tvalid[0]), 32'(v));
            chk($sformatf("t1_tdata k%0d", k),  32'(tdata[0]),  32'(v ? k - 2 : 0));
        end
        wr_en[0] = 1'b0;

        // Mode 0 backpressure with tready pattern 1,0,0,1
        bocc = 0; binfl = 0; nrx = 0; hold_v = 1'b0; hold_d = '0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            wr_en[0]   = (k < 8);
            wr_word[0] = w(8'(8'h11 + k), 1'b0);
            tready[0]  = (k % 4 == 0) || (k % 4 == 3);
            #1;
            pop = tvalid[0] && tready[0];
            chk($sformatf("t2_tvalid k%0d", k), 32'(tvalid[0]), 32'(bocc != 0));
            if (hold_v) chk($sformatf("t2_hold k%0d", k), 32'(tdata[0]), 32'(hold_d));
            chk($sformatf("t2_rd_en k%0d", k), 32'(rd_en[0]),
                32'(!rd_empty[0] && (bocc + binfl - int'(pop) < 2)));
            if (pop && nrx < 16) begin
                rx[nrx] = tdata[0];
                nrx++;
            end
            hold_v = tvalid[0] && !tready[0];
            hold_d = tdata[0];
            bocc   = bocc + int'(rd_valid[0]) - int'(pop);
            binfl  = int'(rd_en[0]);
        end
        wr_en[0] = 1'b0; tready[0] = 1'b1;
        chk("t2_count", 32'(nrx), 32'd8);
        for (int i = 0; i < 8; i++) chk($sformatf("t2_rx%0d", i), 32'(rx[i]), 32'(8'h11 + i));

        // Mode 1 packet held until tlast is written
        for (int k = 0; k < 22; k++) begin
            @(negedge clk);
            wr_en[1]   = (k < 3) || (k == 12);
            wr_word[1] = w(8'(8'hA1 + (k < 3 ? k : 3)), k == 12);
            #1;
            v = (k >= 15 && k <= 18);
            chk($sformatf("t3_rd_en k%0d", k),  32'(rd_en[1]),  32'(k >= 13 && k <= 16));
            chk($sformatf("t3_tvalid k%0d", k), 32'(tvalid[1]), 32'(v));
            chk($sformatf("t3_tdata k%0d", k),  32'(tdata[1]),  32'(v ? 8'hA1 + k - 15 : 0));
            chk($sformatf("t3_tlast k%0d", k),  32'(tlast[1]),  32'(k == 18));
            chk($sformatf("t3_pcnt k%0d", k),   32'(pcnt[1]),   32'(k >= 13 && k <= 18));
            chk($sformatf("t3_pflush k%0d", k), 32'(pflush[1]), 32'd0);
        end
        wr_en[1] = 1'b0;

        // Mode 1 overflow forces release of a tlast-less group
        for (int k = 0; k < 38; k++) begin
            @(negedge clk);
            wr_en[1]   = (k < 16);
            wr_word[1] = w(8'(8'hB0 + k), 1'b0);
            #1;
            v = (k >= 19 && k <= 34);
            chk($sformatf("t4_pflush k%0d", k), 32'(pflush[1]), 32'(k == 17));
            chk($sformatf("t4_pcnt k%0d", k),   32'(pcnt[1]),   32'(k >= 17 && k <= 34));
            chk($sformatf("t4_rd_en k%0d", k),  32'(rd_en[1]),  32'(k >= 17 && k <= 32));
            chk($sformatf("t4_tvalid k%0d", k), 32'(tvalid[1]), 32'(v));
            chk($sformatf("t4_tdata k%0d", k),  32'(tdata[1]),  32'(v ? 8'hB0 + k - 19 : 0));
        end
        chk("t4_full_after", 32'(wr_full[1]), 32'd0);
        wr_en[1] = 1'b0;

        // Mode 1 commit of B on the same edge as A's tlast handshake
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            wr_en[1] = (k == 0) || (k == 1) || (k == 4) || (k == 5);
            case (k)
                0:       wr_word[1] = w(8'hC1, 1'b0);
                1:       wr_word[1] = w(8'hC2, 1'b1);
                4:       wr_word[1] = w(8'hD1, 1'b0);
                default: wr_word[1] = w(8'hD2, 1'b1);
            endcase
            #1;
            v = (k == 4) || (k == 5) || (k == 8) || (k == 9);
            chk($sformatf("t5_pcnt k%0d", k),   32'(pcnt[1]),   32'(k >= 2 && k <= 9));
            chk($sformatf("t5_tvalid k%0d", k), 32'(tvalid[1]), 32'(v));
            chk($sformatf("t5_tlast k%0d", k),  32'(tlast[1]),  32'(k == 5 || k == 9));
            chk($sformatf("t5_tdata k%0d", k),  32'(tdata[1]),
                32'(k == 4 ? 8'hC1 : k == 5 ? 8'hC2 : k == 8 ? 8'hD1 : k == 9 ? 8'hD2 : 8'h00));
            chk($sformatf("t5_rd_en k%0d", k),  32'(rd_en[1]),  32'(k == 2 || k == 3 || k == 6 || k == 7));
        end
        wr_en[1] = 1'b0;

        // Reset with two words parked in the output buffer
        tready[1] = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            wr_en[1]   = (k < 3);
            wr_word[1] = w(8'(8'hE1 + k), k == 2);
            #1;
            chk($sformatf("t6_rd_en k%0d", k), 32'(rd_en[1]), 32'(k == 3 || k == 4));
        end
        chk("t6_pre_tvalid", 32'(tvalid[1]), 32'd1);
        chk("t6_pre_tdata",  32'(tdata[1]),  32'hE1);
        chk("t6_pre_pcnt",   32'(pcnt[1]),   32'd1);
        wr_en[1] = 1'b0;
        arst = 1'b1;
        @(negedge clk);
        arst = 1'b0;
        #1;
        chk("t6_tvalid", 32'(tvalid[1]), 32'd0);
        chk("t6_tdata",  32'(tdata[1]),  32'd0);
        chk("t6_tkeep",  32'(tkeep[1]),  32'd0);
        chk("t6_tlast",  32'(tlast[1]),  32'd0);
        chk("t6_tuser",  32'(tuser[1]),  32'd0);
        chk("t6_tdest",  32'(tdest[1]),  32'd0);
        chk("t6_rd_en",  32'(rd_en[1]),  32'd0);
        chk("t6_pcnt",   32'(pcnt[1]),   32'd0);
        chk("t6_pflush", 32'(pflush[1]), 32'd0);
        tready[1] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            wr_en[1]   = (k < 3);
            wr_word[1] = w(8'(8'hF1 + k), k == 2);
            #1;
            v = (k >= 5 && k <= 7);
            chk($sformatf("t6b_rd_en k%0d", k),  32'(rd_en[1]),  32'(k >= 3 && k <= 5));
            chk($sformatf("t6b_tvalid k%0d", k), 32'(tvalid[1]), 32'(v));
            chk($sformatf("t6b_tdata k%0d", k),  32'(tdata[1]),  32'(v ? 8'hF1 + k - 5 : 0));
            chk($sformatf("t6b_tkeep k%0d", k),  32'(tkeep[1]),  32'(v));
            chk($sformatf("t6b_tlast k%0d", k),  32'(tlast[1]),  32'(k == 7));
            chk($sformatf("t6b_pcnt k%0d", k),   32'(pcnt[1]),   32'(k >= 3 && k <= 7));
        end
        wr_en[1] = 1'b0;
        chk("mode0_pcnt", 32'(pcnt[0]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/axis_fifo_ctrl_sc.md
Name: axis_fifo_ctrl_sc

Overview:
Single-clock successor to the AXIS FIFO read controller. It sits between a single-clock util_fifo instance and an AXI-Stream master port. It unpacks FIFO words into AXIS fields and drives a 2-entry registered output buffer, so outputs stay stable under backpressure at full throughput. It adds an exact word-granular store-and-forward mode with forced release on overflow, plus packet-count and flush status outputs.

Parameters:
BUS_WIDTH, 1, tdata bytes; tkeep width.
USER_WIDTH, 1, tuser width.
DEST_WIDTH, 1, tdest width.
FIFO_POWER, 8, log2 FIFO depth; counters are FIFO_POWER+1 bits.
PACKET_MODE, 0, 0 = stream-through; 1 = store-and-forward.

Ports:
aclk  in  1  sole clock
arst  in  1  synchronous reset, active-high
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  downstream ready
m_axis_tdata  out  BUS_WIDTH*8  data
m_axis_tkeep  out  BUS_WIDTH  byte enables
m_axis_tlast  out  1  end of packet
m_axis_tuser  out  USER_WIDTH  user sideband
m_axis_tdest  out  DEST_WIDTH  destination
wr_en  in  1  FIFO write strobe (write side, observed only)
wr_tlast  in  1  tlast bit of the word being written
wr_full  in  1  FIFO full
rd_en  out  1  FIFO read strobe
rd_valid  in  1  read data valid; asserts exactly 1 cycle after an accepted rd_en
rd_data  in  BUS_WIDTH*8+BUS_WIDTH+USER_WIDTH+DEST_WIDTH+1  packed word, MSB to LSB: tdata, tkeep, tuser, tdest, tlast (bit 0)
rd_empty  in  1  FIFO empty
pkt_count  out  FIFO_POWER+1  committed packets not yet handed off on AXIS
pkt_flush  out  1  one-cycle pulse when a partial packet is force-released

Behaviour:
- Reset (arst=1 at aclk edge):
  - All outputs are 0: tvalid, tdata, tkeep, tlast, tuser, tdest, rd_en, pkt_count, pkt_flush.
  - The buffer, in-flight flag, and all counters clear.
  - Reset mid-packet discards buffered words; no partial-packet state survives.
- Output buffer:
  - 2-entry FIFO of unpacked words; m_axis_* are driven from the head register only.
  - A handshake (tvalid & tready) pops the head.
  - While tvalid=1 and tready=0, every m_axis_* output holds stable.
  - Fields are 0 when tvalid=0.
- Read issue:
  - inflight = registered copy of the previous rd_en; pop = handshake this cycle.
  - rd_en = !rd_empty & allow & (occ + inflight - pop < 2).
  - A word returned by rd_valid is written to the buffer tail at the following edge.
  - Latency: rd_en in cycle N, rd_valid in N+1, tvalid in N+2.
  - Sustains 1 word/cycle with tready held high.
- PACKET_MODE=0: allow=1.
- PACKET_MODE=1 uses two counters:
  - pend: words written since the last commit.
  - rel: released words not yet read.
  - An accepted write is wr_en & !wr_full.
  - Accepted write with wr_tlast=1 commits: rel += pend+1, pend=0, pkt_count += 1.
  - Accepted write with wr_tlast=0: pend += 1.
  - Forced release on the wr_full rising edge (1-cycle registered detect) with pend>0: rel += pend, pend=0, pkt_count += 1, pkt_flush=1 for one cycle.
  - allow = (rel>0); each rd_en decrements rel.
  - Simultaneous commit and rd_en: rel += pend+1-1, applied in one update.
- pkt_count:
  - Decrements on a handshake with m_axis_tlast=1.
  - Decrements on a handshake of the last word of a force-released group; a per-entry flush-tail flag travels through the buffer for this.
  - Increment and decrement in the same cycle leave it unchanged.
  - Saturates at 2^FIFO_POWER and never wraps below 0.
  - In PACKET_MODE=0, pkt_count and pkt_flush are held at 0.
- Width rule: all counter arithmetic is FIFO_POWER+1 bits wide and unsigned.

Test Plan:
- Mode 0, BUS_WIDTH=1, tready=1, write words 0x01..0x08 -> rd_en seen 1 cycle later; tvalid on 8 consecutive cycles carrying 0x01..0x08 in order, tvalid first asserting 2 cycles after the first rd_en.
- Mode 0, tready toggling 1,0,0,1 -> outputs held constant while tready=0; no word lost or duplicated; rd_en is never asserted while occ + inflight - pop is 2.
- Mode 1, write a 4-word packet with tlast held off 10 cycles -> rd_en stays 0 until the cycle after the tlast write; then 4 words output back-to-back with tlast on word 4; pkt_count goes 0 -> 1 -> 0.
- Mode 1, FIFO_POWER=4, write 16 words with no tlast -> wr_full rises, pkt_flush pulses once, 16 words drain, pkt_count returns to 0.
- Mode 1, commit packet B in the same cycle packet A's tlast word handshakes -> pkt_count stays 1; B released intact.
- Assert arst mid-packet with 2 words buffered -> next cycle all outputs are 0 and pkt_count=0; a subsequent 3-word packet passes cleanly.
